// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state bus responder owning a word-addressed RAM
// Define MEM_RESP_BYTEEN_EN to add per-byte write enables on port byte_en.
module mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] address,
    inout  wire  [31:0]           data,
`ifdef MEM_RESP_BYTEEN_EN
    input  logic [3:0]            byte_en,
`endif
    output logic                  ready,
    output logic                  err
);
    localparam int IDX_W = $clog2(DEPTH);
    // Byte-address limit; comparing the full address equals comparing address[ADDR_WIDTH-1:2] against DEPTH.
    localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH+1)'(DEPTH) << 2;
    // The capture cycle is followed by WAIT_STATES further cycles, so RESP is entered at edge N+1+WAIT_STATES.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [IDX_W-1:0]  idx_q;
    logic              oor_q;
    logic              rw_q;
    logic              drive_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem [DEPTH];
    logic              in_range;
    logic              commit;

`ifdef MEM_RESP_BYTEEN_EN
    logic [3:0]        be_q;
`else
    wire  [3:0]        be_q = 4'hF;
`endif

    assign in_range = ({1'b0, address} < BYTE_LIMIT);
    assign commit   = (state == S_WAIT) && (wait_cnt == 4'd0) && !reset;
    assign data     = drive_q ? rdata_q : 32'bz;

    always_ff @(posedge clock) begin
        if (commit && rw_q && !oor_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            ready    <= 1'b0;
            err      <= 1'b0;
            drive_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready   <= 1'b0;
                    err     <= 1'b0;
                    drive_q <= 1'b0;
                    if (req) begin
                        idx_q    <= address[2 +: IDX_W];
                        oor_q    <= !in_range;
                        rw_q     <= rw;
                        wdata_q  <= data;
`ifdef MEM_RESP_BYTEEN_EN
                        be_q     <= byte_en;
`endif
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state   <= S_RESP;
                        ready   <= 1'b1;
                        err     <= oor_q;
                        drive_q <= !rw_q;
                        if (!rw_q) begin
                            rdata_q <= oor_q ? 32'h0 : mem[idx_q];
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    ready   <= 1'b0;
                    err     <= 1'b0;
                    drive_q <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    ready   <= 1'b0;
                    err     <= 1'b0;
                    drive_q <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (WAIT_STATES 1, 0 and 3)
module tb_mem_responder;
    localparam int NI = 3;
    localparam int WS0 = 1;
    localparam int WS1 = 0;
    localparam int WS2 = 3;
    localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst     [NI];
    logic        req_s   [NI];
    logic        rw_s    [NI];
    logic [31:0] addr_s  [NI];
    logic        drv_en  [NI];
    logic [31:0] drv_val [NI];
    logic        ready_o [NI];
    logic        err_o   [NI];
`ifdef MEM_RESP_BYTEEN_EN
    logic [3:0]  be_s    [NI];
`endif
    tri1 [31:0]  bus0;
    tri1 [31:0]  bus1;
    tri1 [31:0]  bus2;

    int total = 0;
    int bad = 0;
    logic [31:0] model [NI][1024];

    assign bus0 = drv_en[0] ? drv_val[0] : 32'bz;
    assign bus1 = drv_en[1] ? drv_val[1] : 32'bz;
    assign bus2 = drv_en[2] ? drv_val[2] : 32'bz;

    mem_responder #(.DEPTH(1024), .WAIT_STATES(WS0), .ADDR_WIDTH(32)) u0 (
        .clock(clock), .reset(rst[0]), .req(req_s[0]), .rw(rw_s[0]),
        .address(addr_s[0]), .data(bus0),
`ifdef MEM_RESP_BYTEEN_EN
        .byte_en(be_s[0]),
`endif
        .ready(ready_o[0]), .err(err_o[0]));

    mem_responder #(.DEPTH(1024), .WAIT_STATES(WS1), .ADDR_WIDTH(32)) u1 (
        .clock(clock), .reset(rst[1]), .req(req_s[1]), .rw(rw_s[1]),
        .address(addr_s[1]), .data(bus1),
`ifdef MEM_RESP_BYTEEN_EN
        .byte_en(be_s[1]),
`endif
        .ready(ready_o[1]), .err(err_o[1]));

    mem_responder #(.DEPTH(1024), .WAIT_STATES(WS2), .ADDR_WIDTH(32)) u2 (
        .clock(clock), .reset(rst[2]), .req(req_s[2]), .rw(rw_s[2]),
        .address(addr_s[2]), .data(bus2),
`ifdef MEM_RESP_BYTEEN_EN
        .byte_en(be_s[2]),
`endif
        .ready(ready_o[2]), .err(err_o[2]));

    function automatic logic [31:0] bus_val(input int k);
        case (k)
            0:       return bus0;
            1:       return bus1;
            default: return bus2;
        endcase
    endfunction

    function automatic int ws_of(input int k);
        case (k)
            0:       return WS0;
            1:       return WS1;
            default: return WS2;
        endcase
    endfunction

    function automatic logic [3:0] eff_be(input logic [3:0] b);
`ifdef MEM_RESP_BYTEEN_EN
        return b;
`else
        return b | 4'hF;
`endif
    endfunction

    function automatic void model_write(input int k, input logic [31:0] a, input logic [31:0] wd,
                                        input logic [3:0] b);
        logic [31:0] r;
        logic [3:0]  e;
        if (a < 32'h1000) begin
            r = model[k][a[11:2]];
            e = eff_be(b);
            for (int i = 0; i < 4; i++) begin
                if (e[i]) r[8*i +: 8] = wd[8*i +: 8];
            end
            model[k][a[11:2]] = r;
        end
    endfunction

    task automatic run_txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] b, output int lat, output bit e, output logic [31:0] rd,
                           output int pulses, output int bus_bad);
        int win;
        win = ws_of(k) + 6;
        lat = -1; e = 1'b0; rd = 32'h0; pulses = 0; bus_bad = 0;
        @(negedge clock);
        req_s[k] = 1'b1; rw_s[k] = w; addr_s[k] = a; drv_en[k] = w; drv_val[k] = wd;
`ifdef MEM_RESP_BYTEEN_EN
        be_s[k] = b;
`endif
        @(posedge clock);
        #1;
        req_s[k] = 1'b0; drv_en[k] = 1'b0; rw_s[k] = ~w; addr_s[k] = $urandom;
        drv_val[k] = $urandom;
        for (int c = 0; c < win; c++) begin
            @(negedge clock);
            if (ready_o[k]) begin
                pulses++;
                if (lat < 0) begin
                    lat = c; e = err_o[k]; rd = bus_val(k);
                end
                if (w && bus_val(k) !== RELEASED) bus_bad++;
            end else if (bus_val(k) !== RELEASED) begin
                bus_bad++;
            end
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; req_s[k] = 1'b0; rw_s[k] = 1'b0; addr_s[k] = 32'h0;
            drv_en[k] = 1'b0; drv_val[k] = 32'h0;
`ifdef MEM_RESP_BYTEEN_EN
            be_s[k] = 4'hF;
`endif
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < NI; k++) begin
            total++; if (ready_o[k] !== 1'b0) begin bad++; $display("FAIL rst_ready[%0d]: got %b want 0", k, ready_o[k]); end
            total++; if (err_o[k] !== 1'b0) begin bad++; $display("FAIL rst_err[%0d]: got %b want 0", k, err_o[k]); end
            total++; if (bus_val(k) !== RELEASED) begin bad++; $display("FAIL rst_bus[%0d]: got %h want released", k, bus_val(k)); end
            rst[k] = 1'b0;
        end
        @(negedge clock);
        for (int k = 0; k < NI; k++) begin
            total++; if (ready_o[k] !== 1'b0) begin bad++; $display("FAIL post_rst_ready[%0d]: got %b want 0", k, ready_o[k]); end
        end
    endtask

    task automatic test_write_latency;
        int lat, p, bb; bit e; logic [31:0] rd;
        run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, e, rd, p, bb);
        model_write(0, 32'h10, 32'hDEADBEEF, 4'hF);
        total++; if (lat !== 2) begin bad++; $display("FAIL wr_lat: got %0d want 2", lat); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", e); end
        total++; if (p !== 1) begin bad++; $display("FAIL wr_pulses: got %0d want 1", p); end
        total++; if (bb !== 0) begin bad++; $display("FAIL wr_bus_driven: got %0d cycles want 0", bb); end
    endtask

    task automatic test_read_back;
        int lat, p, bb; bit e; logic [31:0] rd;
        run_txn(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, e, rd, p, bb);
        total++; if (lat !== 2) begin bad++; $display("FAIL rd_lat: got %0d want 2", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", rd); end
        total++; if (p !== 1) begin bad++; $display("FAIL rd_pulses: got %0d want 1", p); end
        total++; if (bb !== 0) begin bad++; $display("FAIL rd_bus_outside: got %0d cycles want 0", bb); end
        run_txn(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, lat, e, rd, p, bb);
        model_write(1, 32'h10, 32'hCAFEF00D, 4'hF);
        total++; if (lat !== 1) begin bad++; $display("FAIL ws0_wr_lat: got %0d want 1", lat); end
        run_txn(1, 1'b0, 32'h10, 32'h0, 4'hF, lat, e, rd, p, bb);
        total++; if (lat !== 1) begin bad++; $display("FAIL ws0_rd_lat: got %0d want 1", lat); end
        total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL ws0_rd_data: got %h want cafef00d", rd); end
        total++; if (bb !== 0) begin bad++; $display("FAIL ws0_rd_bus: got %0d cycles want 0", bb); end
    endtask

    task automatic test_out_of_range;
        int lat, p, bb; bit e; logic [31:0] rd;
        run_txn(0, 1'b1, 32'h0, 32'h12345678, 4'hF, lat, e, rd, p, bb);
        model_write(0, 32'h0, 32'h12345678, 4'hF);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL oor_setup_err: got %b want 0", e); end
        run_txn(0, 1'b0, 32'h1000, 32'h0, 4'hF, lat, e, rd, p, bb);
        total++; if (p !== 1) begin bad++; $display("FAIL oor_rd_pulses: got %0d want 1", p); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_rd_err: got %b want 1", e); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_rd_data: got %h want 00000000", rd); end
        run_txn(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, lat, e, rd, p, bb);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_wr_err: got %b want 1", e); end
        run_txn(0, 1'b0, 32'h0, 32'h0, 4'hF, lat, e, rd, p, bb);
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL oor_alias: got %h want 12345678", rd); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL oor_alias_err: got %b want 0", e); end
    endtask

    task automatic test_reset_mid_write;
        int lat, p, bb; bit e; logic [31:0] rd;
        run_txn(2, 1'b1, 32'h20, 32'h11, 4'hF, lat, e, rd, p, bb);
        model_write(2, 32'h20, 32'h11, 4'hF);
        total++; if (lat !== 4) begin bad++; $display("FAIL ws3_wr_lat: got %0d want 4", lat); end
        @(negedge clock);
        req_s[2] = 1'b1; rw_s[2] = 1'b1; addr_s[2] = 32'h20; drv_en[2] = 1'b1; drv_val[2] = 32'h55;
        @(posedge clock);
        #1;
        req_s[2] = 1'b0; drv_en[2] = 1'b0;
        @(negedge clock);
        rst[2] = 1'b1;
        @(negedge clock);
        rst[2] = 1'b0;
        p = 0; bb = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (ready_o[2]) p++;
            if (bus_val(2) !== RELEASED) bb++;
        end
        total++; if (p !== 0) begin bad++; $display("FAIL abort_ready: got %0d pulses want 0", p); end
        total++; if (bb !== 0) begin bad++; $display("FAIL abort_bus: got %0d cycles want 0", bb); end
        run_txn(2, 1'b0, 32'h20, 32'h0, 4'hF, lat, e, rd, p, bb);
        total++; if (rd !== 32'h11) begin bad++; $display("FAIL abort_readback: got %h want 00000011", rd); end
        total++; if (lat !== 4) begin bad++; $display("FAIL ws3_rd_lat: got %0d want 4", lat); end
    endtask

    task automatic test_back_to_back;
        int lat, p, bb; bit e; logic [31:0] rd;
        int np; int p_start [4]; int p_len [4]; logic [31:0] p_data [4];
        bit prev;
        run_txn(0, 1'b1, 32'h14, 32'h0BADF00D, 4'hF, lat, e, rd, p, bb);
        model_write(0, 32'h14, 32'h0BADF00D, 4'hF);
        np = 0; prev = 1'b0;
        for (int i = 0; i < 4; i++) begin p_start[i] = 0; p_len[i] = 0; p_data[i] = 32'h0; end
        @(negedge clock);
        req_s[0] = 1'b1; rw_s[0] = 1'b0; addr_s[0] = 32'h10;
        @(posedge clock);
        #1;
        addr_s[0] = 32'h14;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (ready_o[0]) begin
                if (!prev && np < 4) begin
                    p_start[np] = c; p_data[np] = bus_val(0); p_len[np] = 0; np++;
                    if (np == 2) req_s[0] = 1'b0;
                end
                if (np > 0 && np <= 4) p_len[np-1]++;
            end
            prev = ready_o[0];
        end
        req_s[0] = 1'b0;
        total++; if (np !== 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", np); end
        total++; if (p_len[0] !== 1) begin bad++; $display("FAIL b2b_len0: got %0d want 1", p_len[0]); end
        total++; if (p_len[1] !== 1) begin bad++; $display("FAIL b2b_len1: got %0d want 1", p_len[1]); end
        total++; if (p_start[1] - p_start[0] - p_len[0] < 1) begin
            bad++; $display("FAIL b2b_gap: got %0d want >=1", p_start[1] - p_start[0] - p_len[0]);
        end
        total++; if (p_data[0] !== model[0][4]) begin bad++; $display("FAIL b2b_data0: got %h want %h", p_data[0], model[0][4]); end
        total++; if (p_data[1] !== model[0][5]) begin bad++; $display("FAIL b2b_data1: got %h want %h", p_data[1], model[0][5]); end
    endtask

`ifdef MEM_RESP_BYTEEN_EN
    task automatic test_byte_en;
        int lat, p, bb; bit e; logic [31:0] rd;
        run_txn(0, 1'b1, 32'h30, 32'h11223344, 4'hF, lat, e, rd, p, bb);
        run_txn(0, 1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, lat, e, rd, p, bb);
        run_txn(0, 1'b0, 32'h30, 32'h0, 4'hF, lat, e, rd, p, bb);
        total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL be_merge: got %h want 11bb33dd", rd); end
        run_txn(0, 1'b1, 32'h30, 32'h00000000, 4'b0000, lat, e, rd, p, bb);
        total++; if (p !== 1) begin bad++; $display("FAIL be_zero_ready: got %0d want 1", p); end
        run_txn(0, 1'b0, 32'h30, 32'h0, 4'b0000, lat, e, rd, p, bb);
        total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL be_zero_keep: got %h want 11bb33dd", rd); end
        model[0][12] = 32'h11BB33DD;
    endtask
`endif

    task automatic test_random;
        int lat, p, bb; bit e; logic [31:0] rd; bit w; logic [31:0] a; logic [31:0] wd; logic [3:0] b;
        bit exp_err;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 16; i++) begin
                wd = $urandom;
                run_txn(k, 1'b1, 32'h100 + 32'(i) * 4, wd, 4'hF, lat, e, rd, p, bb);
                model_write(k, 32'h100 + 32'(i) * 4, wd, 4'hF);
            end
            for (int i = 0; i < 20; i++) begin
                w = $urandom_range(0, 1) == 1;
                wd = $urandom;
                b = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 5) == 0) a = 32'h1000 + ($urandom & 32'h0FFF_FFFF);
                else a = 32'h100 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
                exp_err = (a >= 32'h1000);
                run_txn(k, w, a, wd, b, lat, e, rd, p, bb);
                total++; if (lat !== 1 + ws_of(k)) begin bad++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", k, lat, 1 + ws_of(k)); end
                total++; if (e !== exp_err) begin bad++; $display("FAIL rnd_err[%0d] a=%h: got %b want %b", k, a, e, exp_err); end
                total++; if (p !== 1) begin bad++; $display("FAIL rnd_pulses[%0d]: got %0d want 1", k, p); end
                total++; if (bb !== 0) begin bad++; $display("FAIL rnd_bus[%0d]: got %0d cycles want 0", k, bb); end
                if (!w) begin
                    total++;
                    if (rd !== (exp_err ? 32'h0 : model[k][a[11:2]])) begin
                        bad++; $display("FAIL rnd_rdata[%0d] a=%h: got %h want %h", k, a, rd,
                                        exp_err ? 32'h0 : model[k][a[11:2]]);
                    end
                end else begin
                    model_write(k, a, wd, b);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_read_back();
        test_out_of_range();
        test_reset_mid_write();
        test_back_to_back();
`ifdef MEM_RESP_BYTEEN_EN
        test_byte_en();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
